sel_capture_bank: RTL and testbench
===================================

Name: sel_capture_bank

Overview:
Multi-channel, parametrised capture register bank. It replaces the single level-sensitive "hold when sel=0" storage element with clocked, enable-qualified capture registers. Each channel holds its last selected data and keeps a saturating capture count. A shared history ring buffer logs capture events for later readout. It is used in procedural-block labs and bench infrastructure wherever "load when select" storage is needed without inferring latches.

Parameters:
WIDTH, 8, data width per channel
NCH, 4, number of channels (1..16)
DEPTH, 16, history buffer entries (power of two, >=2)
CNT_W, 3, per-channel capture counter width
TRANSPARENT, 0, 1 = y forwards din combinationally while sel is high (latch-equivalent view); 0 = y is registered only

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
sel  input  NCH  per-channel capture enable
din  input  NCH*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH]
clr_cnt  input  1  synchronous clear of all capture counters
y  output  NCH*WIDTH  per-channel held data
cap_cnt  output  NCH*CNT_W  per-channel saturating capture counts
rd_en  input  1  pop oldest history entry
rd_data  output  WIDTH  data field of the history head
rd_ch  output  $clog2(NCH) (min 1)  channel index of the history head
empty  output  1  history buffer empty
full  output  1  history buffer full
ovf  output  1  sticky: a capture event was dropped because the buffer was full

Behaviour:
- Reset (rst=1 at posedge): all held registers, cap_cnt, ovf, read/write pointers and occupancy go to 0. After reset: empty=1, full=0, y=0 (when TRANSPARENT=1, y follows din on any channel with sel=1). rst has priority over every other input.
- Capture: sel[i]=1 at posedge -> held[i] <= din[i], visible on y one cycle later. sel[i]=0 -> held[i] unchanged.
- TRANSPARENT=1: y[i] = sel[i] ? din[i] : held[i], combinationally. TRANSPARENT=0: y[i] = held[i]. No latch is inferred in either mode.
- cap_cnt[i]: increments on each cycle with sel[i]=1 and saturates at 2^CNT_W-1. clr_cnt=1 forces all counters to 0; clr_cnt has priority over a simultaneous increment. clr_cnt does not affect held data or history.
- History write event: a cycle in which any sel bit is 1. The entry is {idx, din[idx]}, where idx is the lowest-index channel with sel=1. Exactly one entry is written per cycle.
- History read: rd_data and rd_ch always present the head entry (show-ahead). They are 0 when empty. rd_en=1 with empty=0 advances the head. rd_en while empty is ignored.
- Full with a write event and no pop: the entry is dropped, ovf is set and stays set until rst.
- Full with a write event and rd_en in the same cycle: the pop and the write both occur, occupancy stays at DEPTH, and ovf does not set.
- Empty with a write event and rd_en in the same cycle: the pop is ignored and the write occurs. empty deasserts the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits. full = (occupancy==DEPTH), empty = (occupancy==0), both registered-state derived.
- rst asserted mid-operation discards all history contents and clears ovf in the same edge.

Decomposition:
- Package sel_capture_pkg: hist_entry_t struct {ch index, data} parametrised via typedef in the module, CH_W localparam function ($clog2 with min 1), and default parameter constants.
- One sub-module: sel_hist_ring (DEPTH-entry ring buffer with push/pop/full/empty/ovf). The top instantiates it and holds the per-channel capture registers and counters in generate loops.

Test Plan:
- Reset: hold rst=1 for 2 cycles with sel=4'hF and din all 8'hAA -> y=0, cap_cnt=0, empty=1, ovf=0 (TRANSPARENT=0).
- Capture/hold: sel[0]=1 for one cycle with din[0]=8'h05, then sel=0 and din[0]=8'h09 -> y[0]=8'h05 held; cap_cnt[0]=1; one history entry {0, 8'h05}.
- Priority and saturation: sel=4'b1010 for 9 cycles -> cap_cnt[1]=cap_cnt[3]=7 (saturated); history entries all have rd_ch=1; clr_cnt pulsed together with sel -> counts read 0.
- Full/overflow: 17 consecutive write events with no reads (DEPTH=16) -> full=1, ovf=1, head data equals the first captured value. Then one cycle with a write plus rd_en -> occupancy stays 16 and ovf stays 1.
- Drain and wrap: pop all 16 entries -> the sequence matches the write order and empty=1. Then 20 more writes interleaved with reads -> the pointer wrap is correct and no data is lost.
- TRANSPARENT=1 instance: sel[2]=1 with din[2]=8'h3C mid-cycle -> y[2]=8'h3C before the clock edge. sel drops -> y[2] holds 8'h3C.

Source files
------------

// File: rtl/sel_capture_pkg.sv
// sel_capture_pkg
// Shared definitions for the selectable capture register bank.
//   - DEF_* constants : default parameter values used by the bank and its ring
//   - ch_width()      : width of a channel index, never narrower than one bit
//   - ring_op_t       : per-cycle operation decoded by the history ring
package sel_capture_pkg;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_NCH         = 4;
   localparam int DEF_DEPTH       = 16;
   localparam int DEF_CNT_W       = 3;
   localparam int DEF_TRANSPARENT = 0;

   // A single-channel bank still needs a one-bit index field so that the
   // history entry layout stays the same for every configuration.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // What the history ring does on a given clock edge once push and pop
   // requests have been qualified against full and empty.
   typedef enum logic [1:0] {
      RING_IDLE,
      RING_PUSH,
      RING_POP,
      RING_BOTH
   } ring_op_t;

endpackage

// File: rtl/sel_hist_ring.sv
// sel_hist_ring
// DEPTH-entry show-ahead ring buffer that logs capture events.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   push, push_ch,
//   push_data           : write request and the entry to store
//   pop                 : advance the head (ignored while empty)
//   rd_ch, rd_data      : head entry, zero while empty
//   empty, full         : occupancy flags derived from the registered count
//   ovf                 : sticky flag, an entry was dropped because of full
module sel_hist_ring
   import sel_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CH_W  = 2,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [CH_W-1:0]  push_ch,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [CH_W-1:0]  rd_ch,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [CH_W-1:0]  ch;
      logic [WIDTH-1:0] data;
   } hist_entry_t;

   hist_entry_t     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     occ;
   logic            do_pop;
   logic            do_push;
   logic            drop;
   ring_op_t        op;
   hist_entry_t     head;

   assign empty = (occ == '0);
   assign full  = (occ == (AW+1)'(DEPTH));

   // Qualify the raw requests. A pop on an empty ring is meaningless, and a
   // push into a full ring only fits when the same edge frees the head slot.
   // Anything else that arrives while full is lost and flagged.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      drop    = push && full && !do_pop;
      op      = RING_IDLE;
      if (do_push && do_pop) begin
         op = RING_BOTH;
      end else if (do_push) begin
         op = RING_PUSH;
      end else if (do_pop) begin
         op = RING_POP;
      end
   end

   // Pointer, occupancy and overflow bookkeeping. Reset simply forgets the
   // stored entries by zeroing the count, so the storage array itself never
   // needs a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         ovf    <= 1'b0;
      end else begin
         case (op)
            RING_PUSH: begin
               wr_ptr <= wr_ptr + 1'b1;
               occ    <= occ + 1'b1;
            end
            RING_POP: begin
               rd_ptr <= rd_ptr + 1'b1;
               occ    <= occ - 1'b1;
            end
            RING_BOTH: begin
               wr_ptr <= wr_ptr + 1'b1;
               rd_ptr <= rd_ptr + 1'b1;
            end
            default: begin
            end
         endcase
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

   // Entry storage, written only when the push was accepted.
   always_ff @(posedge clk) begin
      if (op == RING_PUSH || op == RING_BOTH) begin
         mem[wr_ptr] <= '{ch: push_ch, data: push_data};
      end
   end

   // Show-ahead head view, forced to zero while there is nothing to read so
   // stale storage never leaks out.
   always_comb begin
      head = mem[rd_ptr];
      if (empty) begin
         head = '0;
      end
   end

   assign rd_ch   = head.ch;
   assign rd_data = head.data;

endmodule

// File: rtl/sel_capture_bank.sv
// sel_capture_bank
// Multi-channel clocked capture bank: each channel loads din when its sel bit
// is high and holds otherwise, keeps a saturating capture count, and every
// cycle with any capture logs the lowest selected channel into a history ring.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   sel [NCH]         : per-channel capture enable
//   din [NCH*WIDTH]   : per-channel data, channel i at [i*WIDTH +: WIDTH]
//   clr_cnt           : clear all capture counters
//   y [NCH*WIDTH]     : per-channel held data (or din while selected when
//                       TRANSPARENT is set)
//   cap_cnt           : per-channel saturating capture counts
//   rd_en             : pop the history head
//   rd_data, rd_ch    : history head entry
//   empty, full, ovf  : history status
module sel_capture_bank
   import sel_capture_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int NCH         = DEF_NCH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TRANSPARENT = DEF_TRANSPARENT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NCH-1:0]            sel,
   input  logic [NCH*WIDTH-1:0]      din,
   input  logic                      clr_cnt,
   output logic [NCH*WIDTH-1:0]      y,
   output logic [NCH*CNT_W-1:0]      cap_cnt,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic [ch_width(NCH)-1:0]  rd_ch,
   output logic                      empty,
   output logic                      full,
   output logic                      ovf
);

   localparam int              CH_W    = ch_width(NCH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             hist_push;
   logic [CH_W-1:0]  hist_ch;
   logic [WIDTH-1:0] hist_data;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [WIDTH-1:0] held;
      logic [CNT_W-1:0] cnt;

      // Clocked replacement for the old "hold when sel is low" latch: the
      // register only loads on an edge where its channel is selected.
      always_ff @(posedge clk) begin
         if (rst) begin
            held <= '0;
         end else if (sel[i]) begin
            held <= din[i*WIDTH +: WIDTH];
         end
      end

      // Capture counter. A clear wins over a simultaneous capture, and the
      // count sticks at its maximum instead of wrapping back to zero.
      always_ff @(posedge clk) begin
         if (rst || clr_cnt) begin
            cnt <= '0;
         end else if (sel[i] && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
      end

      // The transparent view is a plain mux in front of the register, which
      // gives latch-like visibility without any level-sensitive storage.
      if (TRANSPARENT != 0) begin : g_transparent
         assign y[i*WIDTH +: WIDTH] = sel[i] ? din[i*WIDTH +: WIDTH] : held;
      end else begin : g_registered
         assign y[i*WIDTH +: WIDTH] = held;
      end

      assign cap_cnt[i*CNT_W +: CNT_W] = cnt;
   end

   // Pick the lowest-index selected channel for the history log. Scanning
   // from the top down lets the lowest match overwrite the higher ones.
   always_comb begin
      hist_push = |sel;
      hist_ch   = '0;
      hist_data = din[0 +: WIDTH];
      for (int k = NCH - 1; k >= 0; k--) begin
         if (sel[k]) begin
            hist_ch   = CH_W'(k);
            hist_data = din[k*WIDTH +: WIDTH];
         end
      end
   end

   sel_hist_ring #(
      .WIDTH (WIDTH),
      .CH_W  (CH_W),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk       (clk),
      .rst       (rst),
      .push      (hist_push),
      .push_ch   (hist_ch),
      .push_data (hist_data),
      .pop       (rd_en),
      .rd_ch     (rd_ch),
      .rd_data   (rd_data),
      .empty     (empty),
      .full      (full),
      .ovf       (ovf)
   );

endmodule

// File: tb/tb_sel_capture_bank.sv
// tb_sel_capture_bank
// Directed bench for sel_capture_bank: a registered instance (WIDTH=8, NCH=4,
// DEPTH=16, CNT_W=3) exercises capture, counters and the history ring, and a
// transparent instance checks the combinational forwarding path.
module tb_sel_capture_bank;

   logic        clk;
   logic        rst;
   logic [3:0]  sel;
   logic [31:0] din;
   logic        clr_cnt;
   logic [31:0] y;
   logic [11:0] cap_cnt;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic [1:0]  rd_ch;
   logic        empty;
   logic        full;
   logic        ovf;

   logic [3:0]  t_sel;
   logic [31:0] t_din;
   logic [31:0] t_y;
   logic [11:0] t_cap_cnt;
   logic [7:0]  t_rd_data;
   logic [1:0]  t_rd_ch;
   logic        t_empty;
   logic        t_full;
   logic        t_ovf;

   int n_compared;
   int n_mismatched;

   logic [7:0] q[$];
   logic [7:0] exp_head;

   sel_capture_bank #(
      .WIDTH(8), .NCH(4), .DEPTH(16), .CNT_W(3), .TRANSPARENT(0)
   ) dut (
      .clk(clk), .rst(rst), .sel(sel), .din(din), .clr_cnt(clr_cnt),
      .y(y), .cap_cnt(cap_cnt), .rd_en(rd_en), .rd_data(rd_data),
      .rd_ch(rd_ch), .empty(empty), .full(full), .ovf(ovf)
   );

   sel_capture_bank #(
      .WIDTH(8), .NCH(4), .DEPTH(16), .CNT_W(3), .TRANSPARENT(1)
   ) dut_t (
      .clk(clk), .rst(rst), .sel(t_sel), .din(t_din), .clr_cnt(1'b0),
      .y(t_y), .cap_cnt(t_cap_cnt), .rd_en(1'b0), .rd_data(t_rd_data),
      .rd_ch(t_rd_ch), .empty(t_empty), .full(t_full), .ovf(t_ovf)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive the registered instance's inputs, then let one rising edge pass
   // and settle 1 ns after it so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic [3:0] s, input logic [31:0] d,
                                input logic re, input logic cc);
      sel     = s;
      din     = d;
      rd_en   = re;
      clr_cnt = cc;
      @(posedge clk);
      #1;
   endtask

   // One comparison point: count it, and report tag/observed/expected on a
   // mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_compared++;
      assert (observed === expected)
      else begin
         n_mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Linear directed sequence.
   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      t_sel = 4'h0;
      t_din = 32'h0;

      $display("[TB] reset with all channels selected");
      rst = 1'b1;
      applyStimulus(4'hF, 32'hAAAA_AAAA, 1'b0, 1'b0);
      applyStimulus(4'hF, 32'hAAAA_AAAA, 1'b0, 1'b0);
      checkOutput("reset_y", y, 32'h0);
      checkOutput("reset_cnt", cap_cnt, 12'h0);
      checkOutput("reset_empty", empty, 1'b1);
      checkOutput("reset_full", full, 1'b0);
      checkOutput("reset_ovf", ovf, 1'b0);
      checkOutput("reset_rd_data", rd_data, 8'h0);
      rst = 1'b0;

      $display("[TB] single capture then hold");
      applyStimulus(4'b0001, 32'h0000_0005, 1'b0, 1'b0);
      applyStimulus(4'b0000, 32'h0000_0009, 1'b0, 1'b0);
      checkOutput("hold_y", y, 32'h0000_0005);
      checkOutput("hold_cnt", cap_cnt, 12'h001);
      checkOutput("hold_empty", empty, 1'b0);
      checkOutput("hold_rd_ch", rd_ch, 2'd0);
      checkOutput("hold_rd_data", rd_data, 8'h05);
      applyStimulus(4'b0000, 32'h0000_0009, 1'b1, 1'b0);
      checkOutput("pop1_empty", empty, 1'b1);
      checkOutput("pop1_rd_data", rd_data, 8'h00);

      $display("[TB] priority encode and counter saturation");
      for (int k = 0; k < 9; k++) begin
         applyStimulus(4'b1010, {8'hF0, 8'h00, 8'(8'h10 + k), 8'h00}, 1'b0, 1'b0);
      end
      checkOutput("sat_cnt", cap_cnt, 12'hE39);
      checkOutput("sat_y", y, 32'hF000_1805);
      for (int k = 0; k < 9; k++) begin
         checkOutput("prio_rd_ch", rd_ch, 2'd1);
         checkOutput("prio_rd_data", rd_data, 8'(8'h10 + k));
         applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
      end
      checkOutput("prio_empty", empty, 1'b1);
      applyStimulus(4'b1010, 32'hF000_5500, 1'b0, 1'b1);
      sel     = 4'b0000;
      clr_cnt = 1'b0;
      checkOutput("clr_cnt", cap_cnt, 12'h000);
      checkOutput("clr_keeps_y", y, 32'hF000_5505);
      checkOutput("clr_hist_ch", rd_ch, 2'd1);
      checkOutput("clr_hist_data", rd_data, 8'h55);
      applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
      checkOutput("clr_pop_empty", empty, 1'b1);

      $display("[TB] fill to full and overflow");
      for (int k = 0; k < 16; k++) begin
         applyStimulus(4'b0100, {8'h00, 8'(8'h20 + k), 16'h0}, 1'b0, 1'b0);
      end
      checkOutput("fill16_full", full, 1'b1);
      checkOutput("fill16_ovf", ovf, 1'b0);
      applyStimulus(4'b0100, {8'h00, 8'h30, 16'h0}, 1'b0, 1'b0);
      checkOutput("ovf_full", full, 1'b1);
      checkOutput("ovf_set", ovf, 1'b1);
      checkOutput("ovf_head_data", rd_data, 8'h20);
      checkOutput("ovf_head_ch", rd_ch, 2'd2);
      applyStimulus(4'b0100, {8'h00, 8'h40, 16'h0}, 1'b1, 1'b0);
      checkOutput("full_rw_full", full, 1'b1);
      checkOutput("full_rw_ovf", ovf, 1'b1);
      checkOutput("full_rw_head", rd_data, 8'h21);

      $display("[TB] drain in write order");
      for (int j = 0; j < 16; j++) begin
         exp_head = (j < 15) ? 8'(8'h21 + j) : 8'h40;
         checkOutput("drain_data", rd_data, exp_head);
         checkOutput("drain_ch", rd_ch, 2'd2);
         applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
      end
      checkOutput("drain_empty", empty, 1'b1);
      checkOutput("drain_full", full, 1'b0);

      $display("[TB] interleaved writes and reads across pointer wrap");
      for (int k = 0; k < 20; k++) begin
         if (k % 2 == 1) begin
            checkOutput("wrap_head", rd_data, q[0]);
            q.pop_front();
         end
         q.push_back(8'(8'h60 + k));
         applyStimulus(4'b1000, {8'(8'h60 + k), 24'h0}, (k % 2 == 1), 1'b0);
      end
      sel   = 4'b0000;
      rd_en = 1'b0;
      checkOutput("wrap_occupancy_nonempty", empty, 1'b0);
      while (q.size() > 0) begin
         checkOutput("wrap_drain_data", rd_data, q[0]);
         checkOutput("wrap_drain_ch", rd_ch, 2'd3);
         q.pop_front();
         applyStimulus(4'b0000, 32'h0, 1'b1, 1'b0);
      end
      checkOutput("wrap_empty", empty, 1'b1);

      $display("[TB] write with pop while empty");
      applyStimulus(4'b0001, 32'h0000_0077, 1'b1, 1'b0);
      sel   = 4'b0000;
      rd_en = 1'b0;
      checkOutput("empty_rw_empty", empty, 1'b0);
      checkOutput("empty_rw_data", rd_data, 8'h77);
      checkOutput("empty_rw_ch", rd_ch, 2'd0);
      checkOutput("ovf_sticky", ovf, 1'b1);

      $display("[TB] reset mid-operation");
      rst = 1'b1;
      applyStimulus(4'b0010, 32'h0000_9900, 1'b0, 1'b0);
      rst = 1'b0;
      sel = 4'b0000;
      checkOutput("midrst_empty", empty, 1'b1);
      checkOutput("midrst_ovf", ovf, 1'b0);
      checkOutput("midrst_y", y, 32'h0);
      checkOutput("midrst_cnt", cap_cnt, 12'h000);
      checkOutput("midrst_rd_data", rd_data, 8'h00);

      $display("[TB] transparent instance forwarding");
      t_sel = 4'b0100;
      t_din = 32'h003C_0000;
      #1;
      checkOutput("transp_forward", t_y, 32'h003C_0000);
      @(posedge clk);
      #1;
      t_sel = 4'b0000;
      t_din = 32'h0000_0000;
      #1;
      checkOutput("transp_hold", t_y, 32'h003C_0000);
      checkOutput("transp_cnt", t_cap_cnt, 12'h040);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
